// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the VRAM rectangle-fill engine.
package vram_pkg;

    localparam int H_RES  = 160;
    localparam int V_RES  = 120;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    localparam logic [1:0] REG_ORIGIN  = 2'd0;
    localparam logic [1:0] REG_SIZE    = 2'd1;
    localparam logic [1:0] REG_COLOUR  = 2'd2;
    localparam logic [1:0] REG_CONTROL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/vram_port_arbiter.sv
// VRAM port A mux: a CPU write always wins and stalls the engine for that cycle.
module vram_port_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_data,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data,
    output logic              stall
);

    always_comb begin
        stall     = cpu_we & eng_we;
        vram_we   = eng_we;
        vram_addr = eng_addr;
        vram_data = eng_data;
        if (cpu_we) begin
            vram_we   = 1'b1;
            vram_addr = cpu_addr;
            vram_data = cpu_data;
        end
    end

endmodule

// File: rtl/vram_fill_engine.sv
// Rectangle-fill engine: writes one clipped pixel per cycle into VRAM port A,
// sharing the port with the CPU write path.
module vram_fill_engine #(
    parameter int H_RES  = vram_pkg::H_RES,
    parameter int V_RES  = vram_pkg::V_RES,
    parameter int ADDR_W = vram_pkg::ADDR_W,
    parameter int DATA_W = vram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we,
    input  logic [1:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       status,
    output logic              done_pulse,
    input  logic              cpu_vram_we,
    input  logic [ADDR_W-1:0] cpu_vram_addr,
    input  logic [DATA_W-1:0] cpu_vram_data,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data
);
    import vram_pkg::*;

    localparam logic [7:0]        H_RES_8    = 8'(H_RES);
    localparam logic [7:0]        V_RES_8    = 8'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_RES);

    // Clip a requested span to the room left before the frame edge.
    function automatic logic [7:0] clip_span(input logic [7:0] req, input logic [7:0] room);
        return (req < room) ? req : room;
    endfunction

    fill_state_t state;

    logic [7:0]        org_x, size_w, colour_reg;
    logic [6:0]        org_y, size_h;
    logic [7:0]        lat_x, lat_w, lat_colour;
    logic [6:0]        lat_y, lat_h;
    logic [7:0]        clip_w, clip_h, col, row;
    logic [ADDR_W-1:0] row_base;
    logic              done_flag, error_flag;

    logic              eng_we_p1;
    logic [ADDR_W-1:0] eng_addr_p1;
    logic [DATA_W-1:0] eng_data_p1;
    logic              stall;

    logic              ctrl_wr, start, abort;
    logic [7:0]        room_x, room_y, w_clip, h_clip;
    logic [ADDR_W-1:0] y_ext, setup_base, first_addr;
    logic              out_of_frame;
    logic              unused_wdata;

    assign ctrl_wr = reg_we && (reg_addr == REG_CONTROL);
    assign start   = ctrl_wr && reg_wdata[0];
    assign abort   = ctrl_wr && reg_wdata[1];

    assign unused_wdata = ^{reg_wdata[31:23], reg_wdata[15:8]};

    // Setup-cycle clipping and row base; y*160 built from shifts.
    always_comb begin
        room_x       = H_RES_8 - lat_x;
        room_y       = V_RES_8 - {1'b0, lat_y};
        w_clip       = clip_span(lat_w, room_x);
        h_clip       = clip_span({1'b0, lat_h}, room_y);
        out_of_frame = (lat_x >= H_RES_8) || ({1'b0, lat_y} >= V_RES_8);
        y_ext        = ADDR_W'(lat_y);
        setup_base   = (y_ext << 7) + (y_ext << 5);
        first_addr   = setup_base + ADDR_W'(lat_x);
    end

    assign status = {29'b0, error_flag, done_flag, (state != ST_IDLE)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            org_x       <= '0;
            org_y       <= '0;
            size_w      <= '0;
            size_h      <= '0;
            colour_reg  <= '0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_w       <= '0;
            lat_h       <= '0;
            lat_colour  <= '0;
            clip_w      <= '0;
            clip_h      <= '0;
            col         <= '0;
            row         <= '0;
            row_base    <= '0;
            done_flag   <= 1'b0;
            error_flag  <= 1'b0;
            done_pulse  <= 1'b0;
            eng_we_p1   <= 1'b0;
            eng_addr_p1 <= '0;
            eng_data_p1 <= '0;
        end else begin
            done_pulse <= 1'b0;

            if (reg_we) begin
                case (reg_addr)
                    REG_ORIGIN: begin
                        org_x <= reg_wdata[7:0];
                        org_y <= reg_wdata[22:16];
                    end
                    REG_SIZE: begin
                        size_w <= reg_wdata[7:0];
                        size_h <= reg_wdata[22:16];
                    end
                    REG_COLOUR: colour_reg <= reg_wdata[7:0];
                    default: ;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        lat_x      <= org_x;
                        lat_y      <= org_y;
                        lat_w      <= size_w;
                        lat_h      <= size_h;
                        lat_colour <= colour_reg;
                        done_flag  <= 1'b0;
                        error_flag <= 1'b0;
                        state      <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (out_of_frame) begin
                        error_flag <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (w_clip == 8'd0 || h_clip == 8'd0) begin
                        done_flag  <= 1'b1;
                        done_pulse <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        clip_w      <= w_clip;
                        clip_h      <= h_clip;
                        col         <= '0;
                        row         <= '0;
                        row_base    <= setup_base;
                        eng_we_p1   <= 1'b1;
                        eng_addr_p1 <= first_addr;
                        eng_data_p1 <= lat_colour;
                        state       <= ST_RUN;
                    end
                end

                // The pixel in eng_*_p1 is consumed on every non-stalled cycle.
                ST_RUN: begin
                    if (abort) begin
                        eng_we_p1 <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (!stall) begin
                        if (col == clip_w - 8'd1) begin
                            if (row == clip_h - 8'd1) begin
                                eng_we_p1  <= 1'b0;
                                done_flag  <= 1'b1;
                                done_pulse <= 1'b1;
                                state      <= ST_DONE;
                            end else begin
                                col         <= '0;
                                row         <= row + 8'd1;
                                row_base    <= row_base + ROW_STRIDE;
                                eng_addr_p1 <= row_base + ROW_STRIDE + ADDR_W'(lat_x);
                            end
                        end else begin
                            col         <= col + 8'd1;
                            eng_addr_p1 <= eng_addr_p1 + ADDR_W'(1);
                        end
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

    vram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_arbiter (
        .cpu_we    (cpu_vram_we),
        .cpu_addr  (cpu_vram_addr),
        .cpu_data  (cpu_vram_data),
        .eng_we    (eng_we_p1),
        .eng_addr  (eng_addr_p1),
        .eng_data  (eng_data_p1),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .stall     (stall)
    );

endmodule

// File: tb/tb_vram_fill_engine.sv
// Directed bench for vram_fill_engine: table of fills plus hand-written
// sequences for CPU conflicts, abort, ignored start and reset during a fill.
module tb_vram_fill_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] status;
    logic        done_pulse;
    logic        cpu_vram_we;
    logic [14:0] cpu_vram_addr;
    logic [7:0]  cpu_vram_data;
    logic        vram_we;
    logic [14:0] vram_addr;
    logic [7:0]  vram_data;

    vram_fill_engine dut (
        .clk           (clk),
        .rst           (rst),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .status        (status),
        .done_pulse    (done_pulse),
        .cpu_vram_we   (cpu_vram_we),
        .cpu_vram_addr (cpu_vram_addr),
        .cpu_vram_data (cpu_vram_data),
        .vram_we       (vram_we),
        .vram_addr     (vram_addr),
        .vram_data     (vram_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] w;
        logic [6:0] h;
        logic [7:0] colour;
        int         nwr;
        int         first_a;
        int         last_a;
        int         pulse_k;
        int         st_after;
    } vec_t;

    int total = 0;
    int bad   = 0;

    int eng_q[$];
    int pulse_k, pulse_n, idle_k, bad_data, cpu_bad, cpu_seen;
    int cpu_k0, cpu_n;
    int          ev_k[3];
    logic [1:0]  ev_a[3];
    logic [31:0] ev_d[3];

    vec_t vecs[10];
    int   exp4x3[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_events();
        for (int e = 0; e < 3; e++) begin
            ev_k[e] = 0;
            ev_a[e] = 2'd0;
            ev_d[e] = 32'd0;
        end
        cpu_k0 = 0;
        cpu_n  = 0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
    endtask

    task automatic program_fill(input logic [7:0] x, input logic [6:0] y,
                                input logic [7:0] w, input logic [6:0] h,
                                input logic [7:0] c);
        write_reg(2'd0, {9'd0, y, 8'd0, x});
        write_reg(2'd1, {9'd0, h, 8'd0, w});
        write_reg(2'd2, {24'd0, c});
    endtask

    // Starts a fill and observes lim cycles; k counts cycles after the start write.
    task automatic run_fill(input logic [7:0] x, input logic [6:0] y,
                            input logic [7:0] w, input logic [6:0] h,
                            input logic [7:0] c, input int lim);
        eng_q.delete();
        pulse_k  = 0;
        pulse_n  = 0;
        idle_k   = 0;
        bad_data = 0;
        cpu_bad  = 0;
        cpu_seen = 0;
        program_fill(x, y, w, h, c);
        write_reg(2'd3, 32'd1);
        for (int k = 1; k <= lim; k++) begin
            reg_we = 1'b0;
            for (int e = 0; e < 3; e++) begin
                if (ev_k[e] == k) begin
                    reg_we    = 1'b1;
                    reg_addr  = ev_a[e];
                    reg_wdata = ev_d[e];
                end
            end
            cpu_vram_we   = (k >= cpu_k0) && (k < cpu_k0 + cpu_n);
            cpu_vram_addr = 15'(1000 + k);
            cpu_vram_data = 8'(k);
            @(negedge clk);
            if (cpu_vram_we) begin
                cpu_seen++;
                if (!(vram_we && vram_addr == cpu_vram_addr && vram_data == cpu_vram_data))
                    cpu_bad++;
            end else if (vram_we) begin
                eng_q.push_back(int'(vram_addr));
                if (vram_data != c) bad_data++;
            end
            if (done_pulse) begin
                pulse_n++;
                if (pulse_k == 0) pulse_k = k;
            end
            if (!status[0] && idle_k == 0) idle_k = k;
            @(posedge clk);
            #1;
        end
        reg_we      = 1'b0;
        cpu_vram_we = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'd10,  7'd5,   8'd4,   7'd3,  8'hE0, 12,  810,   1133,  14,  2};
        vecs[1] = '{8'd158, 7'd118, 8'd10,  7'd10, 8'h1C, 4,   19038, 19199, 6,   2};
        vecs[2] = '{8'd160, 7'd0,   8'd3,   7'd3,  8'h11, 0,   -1,    -1,    0,   4};
        vecs[3] = '{8'd0,   7'd0,   8'd0,   7'd5,  8'h03, 0,   -1,    -1,    2,   2};
        vecs[4] = '{8'd0,   7'd0,   8'd1,   7'd1,  8'hFF, 1,   0,     0,     3,   2};
        vecs[5] = '{8'd0,   7'd120, 8'd2,   7'd2,  8'h22, 0,   -1,    -1,    0,   4};
        vecs[6] = '{8'd159, 7'd0,   8'd5,   7'd2,  8'h9A, 2,   159,   319,   4,   2};
        vecs[7] = '{8'd0,   7'd119, 8'd160, 7'd5,  8'h5B, 160, 19040, 19199, 162, 2};
        vecs[8] = '{8'd5,   7'd0,   8'd3,   7'd0,  8'h77, 0,   -1,    -1,    2,   2};
        vecs[9] = '{8'd20,  7'd100, 8'd3,   7'd30, 8'hC3, 60,  16020, 19062, 62,  2};
        exp4x3 = '{810, 811, 812, 813, 970, 971, 972, 973, 1130, 1131, 1132, 1133};

        rst           = 1'b1;
        reg_we        = 1'b0;
        reg_addr      = 2'd0;
        reg_wdata     = 32'd0;
        cpu_vram_we   = 1'b0;
        cpu_vram_addr = 15'd0;
        cpu_vram_data = 8'd0;
        clear_events();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_status", int'(status), 0);
        check("rst_done_pulse", int'(done_pulse), 0);
        check("rst_vram_we", int'(vram_we), 0);
        check("rst_vram_addr", int'(vram_addr), 0);
        check("rst_vram_data", int'(vram_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven fills
        for (int i = 0; i < 10; i++) begin
            clear_events();
            run_fill(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].colour, vecs[i].nwr + 8);
            check($sformatf("v%0d_count", i), eng_q.size(), vecs[i].nwr);
            if (vecs[i].nwr > 0) begin
                check($sformatf("v%0d_first", i), (eng_q.size() > 0) ? eng_q[0] : -1, vecs[i].first_a);
                check($sformatf("v%0d_last", i), (eng_q.size() > 0) ? eng_q[eng_q.size()-1] : -1,
                      vecs[i].last_a);
            end
            check($sformatf("v%0d_colour_errs", i), bad_data, 0);
            check($sformatf("v%0d_pulse_k", i), pulse_k, vecs[i].pulse_k);
            check($sformatf("v%0d_pulse_n", i), pulse_n, (vecs[i].pulse_k != 0) ? 1 : 0);
            check($sformatf("v%0d_idle_k", i), idle_k,
                  (vecs[i].pulse_k != 0) ? vecs[i].pulse_k + 1 : 2);
            check($sformatf("v%0d_status", i), int'(status[2:0]), vecs[i].st_after);
        end

        // Exact pixel order of the 4x3 fill
        clear_events();
        run_fill(8'd10, 7'd5, 8'd4, 7'd3, 8'hE0, 20);
        check("ord_count", eng_q.size(), 12);
        for (int j = 0; j < 12; j++)
            check($sformatf("ord_addr%0d", j), (j < eng_q.size()) ? eng_q[j] : -1, exp4x3[j]);

        // CPU writes for two cycles mid-row
        clear_events();
        cpu_k0 = 4;
        cpu_n  = 2;
        run_fill(8'd10, 7'd5, 8'd4, 7'd3, 8'hE0, 22);
        check("cpu_seen", cpu_seen, 2);
        check("cpu_passthru_errs", cpu_bad, 0);
        check("cpu_eng_count", eng_q.size(), 12);
        for (int j = 0; j < 12; j++)
            check($sformatf("cpu_eng_addr%0d", j), (j < eng_q.size()) ? eng_q[j] : -1, exp4x3[j]);
        check("cpu_pulse_k", pulse_k, 16);
        check("cpu_status", int'(status[2:0]), 2);

        // Abort after 5 pixels; origin write and second start mid-fill have no effect
        clear_events();
        ev_k[0] = 3; ev_a[0] = 2'd0; ev_d[0] = {9'd0, 7'd50, 8'd0, 8'd50};
        ev_k[1] = 4; ev_a[1] = 2'd3; ev_d[1] = 32'd1;
        ev_k[2] = 6; ev_a[2] = 2'd3; ev_d[2] = 32'd2;
        run_fill(8'd0, 7'd0, 8'd20, 7'd20, 8'h44, 15);
        check("abort_count", eng_q.size(), 5);
        for (int j = 0; j < 5; j++)
            check($sformatf("abort_addr%0d", j), (j < eng_q.size()) ? eng_q[j] : -1, j);
        check("abort_pulse_n", pulse_n, 0);
        check("abort_idle_k", idle_k, 7);
        check("abort_status", int'(status[2:0]), 0);

        // Start and abort in the same write
        clear_events();
        write_reg(2'd3, 32'd3);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("startabort_busy%0d", k), int'(status[0]), 0);
            check($sformatf("startabort_we%0d", k), int'(vram_we), 0);
            @(posedge clk);
            #1;
        end

        // Reset while the engine is writing
        program_fill(8'd0, 8'd0, 8'd20, 7'd20, 8'h66);
        write_reg(2'd3, 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstrun_pre_we", int'(vram_we), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("rstrun_we%0d", k), int'(vram_we), 0);
            check($sformatf("rstrun_status%0d", k), int'(status), 0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_fill_engine.md
# vram_fill_engine

Rectangle-fill accelerator sitting directly upstream of the VRAM write port (port A). It shares that port with the CPU write path from the MIO bus. Once the CPU programs origin, size and colour through four bus registers and sets start, the engine writes one 8-bit RRRGGGBB pixel per cycle, row-major, clipped to the 160x120 frame. The CPU can poll status or use the one-cycle done pulse as an interrupt source.

## Interface
Parameters:
- H_RES, 160: frame width in pixels.
- V_RES, 120: frame height in pixels.
- ADDR_W, 15: VRAM address width.
- DATA_W, 8: pixel width.

Ports:
- clk  in  1  engine clock; same clock as the CPU-side VRAM write path.
- rst  in  1  reset; synchronous, active-high.
- reg_we  in  1  register write strobe from the bus decoder.
- reg_addr  in  2  register select: 0 origin, 1 size, 2 colour, 3 control.
- reg_wdata  in  32  register write data.
- status  out  32  {29'b0, error, done, busy}.
- done_pulse  out  1  one-cycle pulse when a fill completes normally.
- cpu_vram_we  in  1  CPU VRAM write request.
- cpu_vram_addr  in  ADDR_W  CPU VRAM address.
- cpu_vram_data  in  DATA_W  CPU VRAM data.
- vram_we  out  1  to VRAM port A wea.
- vram_addr  out  ADDR_W  to VRAM port A addra.
- vram_data  out  DATA_W  to VRAM port A dina.

## Operation
Register layout:
- origin: x = [7:0], y = [22:16].
- size: w = [7:0], h = [22:16].
- colour: [7:0].
- control: bit0 start, bit1 abort. Control bits self-clear and are not stored.

Registers 0–2 are writable at any time. The engine latches copies at start, so mid-fill writes affect only the next fill.

FSM states:
- IDLE: waits for start. A start while busy is ignored.
- SETUP (1 cycle):
  - If x ≥ H_RES or y ≥ V_RES: set error, go to IDLE, no writes.
  - Otherwise clip: w' = min(w, H_RES−x), h' = min(h, V_RES−y).
  - If w' = 0 or h' = 0: go to DONE with no writes.
  - Otherwise compute row_base = y·160, as (y<<7) + (y<<5), no multiplier.
- RUN: issues a write at address row_base + x + col. col increments from 0 to w'−1. At the end of a row, col returns to 0, row_base += H_RES and row increments. After pixel (w'−1, h'−1) the FSM goes to DONE.
- DONE (1 cycle): done_pulse = 1, done = 1, then IDLE.

Port arbitration:
- cpu_vram_we always wins. The CPU write passes through combinationally that cycle and the engine stalls, holding col/row.
- When the engine is not writing and the CPU is not writing, vram_we = 0.

Status flags:
- busy = 1 in SETUP, RUN and DONE.
- done and error are sticky. Both clear on the next start.
- abort: from SETUP or RUN goes to IDLE next cycle. No further engine writes, done stays 0, no done_pulse. Abort in IDLE has no effect.
- Start and abort in the same write: abort wins, no fill.

Arithmetic: addresses are unsigned ADDR_W bits. The maximum address (19199) fits without wrap. Clipping guarantees no address exceeds H_RES·V_RES − 1.

## Timing
- Reset values: status = 0, done_pulse = 0, vram_we = 0, vram_addr = 0, vram_data = 0. FSM in IDLE. Latched registers = 0.
- A reset during RUN stops writes from the next cycle.
- Start written at cycle T: SETUP at T+1, first engine write at T+2.
- Without CPU conflicts, the last write is at T+1+w'·h', done_pulse at T+2+w'·h', busy low at T+3+w'·h'.
- Each CPU write during RUN adds exactly one cycle.
- Engine outputs are registered. The CPU pass-through is combinational mux only.

## Structure
- Shared package (vram_pkg): H_RES, V_RES, ADDR_W, DATA_W, register-index constants, fsm state enum.
- One sub-module: vram_port_arbiter, the CPU/engine mux plus stall signal.
- Target size: 150–250 lines.

## Test plan
- origin (10,5), size 4×3, colour 0xE0, start → 12 writes of 0xE0 at 810–813, 970–973, 1130–1133. done_pulse at T+14, status = 0b010 afterwards.
- origin (158,118), size 10×10 → clipped to 2×2. Writes at 19038, 19039, 19198, 19199 only.
- origin (160,0) → no writes, status.error = 1, no done_pulse.
- size 0×5 → no writes, done_pulse at T+2.
- 4×3 fill with cpu_vram_we asserted for 2 cycles mid-row → those cycles carry the CPU address/data. The engine pixel sequence is unchanged, done_pulse at T+16.
- Abort after 5 pixels of a 20×20 fill → exactly 5 engine writes, done = 0, no done_pulse. A start during the same fill while busy is ignored.
